// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// ram_arbiter
//
// Two-port arbiter in front of a single-port-per-direction RAM (asynchronous
// read, synchronous write). Requester A (bit 0) is the core and requester B
// (bit 1) is the loader/debug port. Each cycle at most one requester is
// granted. The winner's address and write data are steered to the RAM, and
// read data comes back registered one cycle later with a per-port RVALID
// pulse. Contention is resolved round-robin. With RAM_ARB_LOCK_EN defined, a
// requester that raises LOCK can keep the grant for up to MAX_LOCK
// consecutive accesses.
//
// Configuration macro: RAM_ARB_LOCK_EN (undefined = pure round-robin, LOCK ignored)
//
// Ports
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_req[1:0]         access request per requester
//   i_we[1:0]          write enable per requester (1 = write)
//   i_addr             {B, A} word addresses
//   i_wdata            {B, A} write data
//   i_lock[1:0]        grant-hold request per requester
//   o_gnt[1:0]         one-hot combinational grant
//   o_rvalid[1:0]      registered read-data-valid pulse per requester
//   o_rdata            registered read data (shared)
//   o_ram_addr_w       RAM write address
//   o_ram_enable_w     RAM write enable
//   o_ram_q_w          RAM write data
//   o_ram_addr_r       RAM read address
//   i_ram_q_r          RAM read data (asynchronous)
//------------------------------------------------------------------------------
module ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_LOCK   = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [1:0]              i_req,
   input  logic [1:0]              i_we,
   input  logic [2*ADDR_WIDTH-1:0] i_addr,
   input  logic [2*DATA_WIDTH-1:0] i_wdata,
   input  logic [1:0]              i_lock,
   output logic [1:0]              o_gnt,
   output logic [1:0]              o_rvalid,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [ADDR_WIDTH-1:0]   o_ram_addr_w,
   output logic                    o_ram_enable_w,
   output logic [DATA_WIDTH-1:0]   o_ram_q_w,
   output logic [ADDR_WIDTH-1:0]   o_ram_addr_r,
   input  logic [DATA_WIDTH-1:0]   i_ram_q_r
);

   localparam int CW = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_last;        // 0 = A won most recently, 1 = B
   logic [CW-1:0]           r_lock_cnt;
   logic [CW-1:0]           w_cnt_inc;
   logic [1:0]              w_gnt;
   logic [1:0]              w_rd_acc;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic                    w_we;
   logic [1:0]              r_rvalid;
   logic [DATA_WIDTH-1:0]   r_rdata;

   // Saturating increment of the lock counter
   assign w_cnt_inc = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : (r_lock_cnt + CW'(1));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: lock ownership entry and release
   always_comb begin
      w_state_next = r_state;
`ifdef RAM_ARB_LOCK_EN
      case (r_state)
         ST_IDLE: begin
            // A counter limit of 1 would release on the entering access, so never own
            if (w_gnt[0] && i_lock[0] && (MAX_LOCK > 1)) begin
               w_state_next = ST_OWN_A;
            end else if (w_gnt[1] && i_lock[1] && (MAX_LOCK > 1)) begin
               w_state_next = ST_OWN_B;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_OWN_A: begin
            // Release is decided on the access that brings the count to MAX_LOCK
            if (!i_lock[0] || !i_req[0] || (w_gnt[0] && (w_cnt_inc == LOCK_MAX))) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_OWN_A;
            end
         end
         ST_OWN_B: begin
            if (!i_lock[1] || !i_req[1] || (w_gnt[1] && (w_cnt_inc == LOCK_MAX))) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_OWN_B;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
`else
      w_state_next = ST_IDLE;
`endif
   end

`ifndef RAM_ARB_LOCK_EN
   logic w_unused_lock;
   assign w_unused_lock = ^i_lock;
`endif

   // Grant logic: owner first, otherwise round-robin between requesters
   always_comb begin
      w_gnt = 2'b00;
      if (i_reset) begin
         w_gnt = 2'b00;
      end else begin
         case (r_state)
            ST_OWN_A: begin
               if (i_req[0])      w_gnt = 2'b01;
               else if (i_req[1]) w_gnt = 2'b10;
               else               w_gnt = 2'b00;
            end
            ST_OWN_B: begin
               if (i_req[1])      w_gnt = 2'b10;
               else if (i_req[0]) w_gnt = 2'b01;
               else               w_gnt = 2'b00;
            end
            default: begin
               case (i_req)
                  2'b01:   w_gnt = 2'b01;
                  2'b10:   w_gnt = 2'b10;
                  2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                  default: w_gnt = 2'b00;
               endcase
            end
         endcase
      end
   end

   // Steer the winner's address, data and direction to the RAM
   always_comb begin
      if (w_gnt[0]) begin
         w_addr  = i_addr[ADDR_WIDTH-1:0];
         w_wdata = i_wdata[DATA_WIDTH-1:0];
         w_we    = i_we[0];
      end else if (w_gnt[1]) begin
         w_addr  = i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
         w_wdata = i_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
         w_we    = i_we[1];
      end else begin
         w_addr  = {ADDR_WIDTH{1'b0}};
         w_wdata = {DATA_WIDTH{1'b0}};
         w_we    = 1'b0;
      end
   end

   assign w_rd_acc = w_gnt & ~i_we;

   // Round-robin pointer and lock counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last     <= 1'b1;
         r_lock_cnt <= {CW{1'b0}};
      end else begin
         if (w_gnt[0])      r_last <= 1'b0;
         else if (w_gnt[1]) r_last <= 1'b1;
         else               r_last <= r_last;

         case (r_state)
            ST_IDLE:  r_lock_cnt <= (w_state_next != ST_IDLE) ? CW'(1) : {CW{1'b0}};
            ST_OWN_A: r_lock_cnt <= w_gnt[0] ? w_cnt_inc : r_lock_cnt;
            ST_OWN_B: r_lock_cnt <= w_gnt[1] ? w_cnt_inc : r_lock_cnt;
            default:  r_lock_cnt <= {CW{1'b0}};
         endcase
      end
   end

   // Read response: capture RAM data and pulse RVALID for the reading winner
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rvalid <= 2'b00;
         r_rdata  <= {DATA_WIDTH{1'b0}};
      end else begin
         r_rvalid <= w_rd_acc;
         if (|w_rd_acc) r_rdata <= i_ram_q_r;
         else           r_rdata <= r_rdata;
      end
   end

   assign o_gnt          = w_gnt;
   assign o_rvalid       = r_rvalid;
   assign o_rdata        = r_rdata;
   assign o_ram_addr_w   = w_addr;
   assign o_ram_addr_r   = w_addr;
   assign o_ram_q_w      = w_wdata;
   assign o_ram_enable_w = w_we & ~i_reset;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 10, shall set the word address width.
REQ-003 Parameter MAX_LOCK, default 8, shall set the maximum consecutive grants a locked requester may hold.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 REQ  input  2  per-requester access request; bit 0 = requester A (core), bit 1 = requester B (loader/debug).
REQ-007 WE  input  2  per-requester write enable; 1 = write, 0 = read.
REQ-008 ADDR  input  2*ADDR_WIDTH  per-requester word address; A in low slice.
REQ-009 WDATA  input  2*DATA_WIDTH  per-requester write data; A in low slice.
REQ-010 LOCK  input  2  per-requester grant-hold request (used only with RAM_ARB_LOCK_EN).
REQ-011 GNT  output  2  one-hot combinational grant; access completes on a cycle where REQ[i] and GNT[i] are both 1.
REQ-012 RVALID  output  2  registered one-cycle pulse marking RDATA valid for requester i.
REQ-013 RDATA  output  DATA_WIDTH  registered read data, shared by both requesters.
REQ-014 RAM_ADDR_W  output  ADDR_WIDTH  write address to RAM.
REQ-015 RAM_ENABLE_W  output  1  RAM write enable.
REQ-016 RAM_Q_W  output  DATA_WIDTH  RAM write data.
REQ-017 RAM_ADDR_R  output  ADDR_WIDTH  RAM read address (RAM read is asynchronous).
REQ-018 RAM_Q_R  input  DATA_WIDTH  RAM read data.

Function
REQ-019 GNT shall be at most one-hot, zero when REQ==0, and shall grant only a requesting port.
REQ-020 With both REQ bits set and no active lock, the winner shall be the port not granted most recently (round-robin pointer LAST).
REQ-021 LAST shall update to the winner on every accepted access and hold otherwise.
REQ-022 RAM_ADDR_W, RAM_ADDR_R and RAM_Q_W shall mux the winner's ADDR/WDATA; with no winner they shall be 0.
REQ-023 RAM_ENABLE_W shall equal 1 only when a winner exists, its WE is 1, and RESET is 0.
REQ-024 On accepted read at cycle n, RDATA shall capture RAM_Q_R at edge n and RVALID[winner] shall be 1 during cycle n+1 only.
REQ-025 RDATA shall hold its value when no read is accepted; RVALID shall never be asserted for writes.
REQ-026 Back-to-back accesses shall sustain one accepted access per cycle with no bubble.
REQ-027 Write at cycle n followed by read of the same address at n+1 shall return the new data; a same-cycle read by the other port is impossible (single grant).
REQ-028 FSM states IDLE, OWN_A, OWN_B shall exist; IDLE -> OWN_i on accepted access by i with LOCK[i]=1; OWN_i -> IDLE when LOCK[i]=0, REQ[i]=0, or lock counter reaches MAX_LOCK.
REQ-029 In OWN_i, GNT shall go to i whenever REQ[i]=1, regardless of the other port.
REQ-030 Lock counter shall reset to 1 on entering OWN_i, increment per accepted access in OWN_i, and saturate; on forced release with the other port requesting, the other port shall win the next cycle.

Reset
REQ-031 While RESET=1: GNT=0, RAM_ENABLE_W=0, RVALID=0, RDATA=0, FSM=IDLE, lock counter=0, LAST=B (so A wins first contention).
REQ-032 A read accepted in the cycle RESET rises shall produce no RVALID pulse.

Configuration
REQ-033 Macro RAM_ARB_LOCK_EN defined: LOCK input and OWN_A/OWN_B states active per REQ-028..030.
REQ-034 RAM_ARB_LOCK_EN undefined: LOCK ignored, FSM stays IDLE, pure round-robin per REQ-020.

Verification
REQ-035 A writes 0xDEADBEEF to addr 5 alone -> GNT=01, RAM_ENABLE_W=1, RAM_ADDR_W=5 that cycle; later A reads 5 -> RVALID=01 next cycle, RDATA=0xDEADBEEF.
REQ-036 A and B read continuously from reset -> GNT sequence 01,10,01,10; RVALID follows one cycle late with matching data.
REQ-037 B writes 0x1234 to addr 7 at cycle n, A reads addr 7 at n+1 -> A receives 0x1234.
REQ-038 With RAM_ARB_LOCK_EN, A holds LOCK=1 and REQ=1 while B requests -> A granted 8 consecutive cycles, then B granted; without macro -> strict alternation.
REQ-039 RESET asserted in the cycle a read is granted -> no RVALID next cycle, RDATA=0, first contention after reset grants A.
